// File: rtl/alu_sched_pkg.sv
// Shared constants and FSM encoding for the two-requester ALU scheduler.
package alu_sched_pkg;

  localparam int W     = 8;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] ALU_ADD = 4'h0;
  localparam logic [SEL_W-1:0] ALU_SUB = 4'h1;

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU; carry-out is the carry for ADD, borrow for SUB,
// and the shifted-out bit for the shifts.
module alu_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] alu_sel,
  input  logic       cin,
  output logic [7:0] alu_out,
  output logic       alu_cout
);

  logic [8:0] wide;

  // Opcode decode.
  always_comb begin
    wide     = 9'd0;
    alu_out  = 8'd0;
    alu_cout = 1'b0;
    case (alu_sel)
      4'h0: begin
        wide     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        alu_out  = wide[7:0];
        alu_cout = wide[8];
      end
      4'h1: begin
        wide     = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        alu_out  = wide[7:0];
        alu_cout = wide[8];
      end
      4'h2: alu_out = a & b;
      4'h3: alu_out = a | b;
      4'h4: alu_out = a ^ b;
      4'h5: alu_out = ~a;
      4'h6: {alu_cout, alu_out} = {a, 1'b0};
      4'h7: begin
        alu_out  = {1'b0, a[7:1]};
        alu_cout = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sched_2req.sv
// Round-robin scheduler sharing one ALU between two requesters, with a grant
// lock for multi-byte chains and per-requester result buffers and carry flags.
module alu_sched_2req
  import alu_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*W-1:0]       req_a,
  input  logic [2*W-1:0]       req_b,
  input  logic [2*SEL_W-1:0]   req_sel,
  input  logic [1:0]           req_use_c,
  input  logic [1:0]           req_lock,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [2*W-1:0]       rsp_out,
  output logic [1:0]           rsp_cout,
  output logic                 busy
);

  state_t               state, state_nxt;
  logic                 ptr, ptr_nxt;
  logic [1:0]           elig, grant;
  logic                 acc_id;

  logic                 iss_vld_p1, iss_id_p1, iss_cin_p1;
  logic [W-1:0]         iss_a_p1, iss_b_p1;
  logic [SEL_W-1:0]     iss_sel_p1;
  logic [W-1:0]         alu_out;
  logic                 alu_cout;

  logic [1:0]           vld_p2, cout_p2, carry;
  logic [1:0][W-1:0]    out_p2;

  // A requester may issue only with nothing of its own in flight.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++)
      elig[i] = req_valid[i] & ~vld_p2[i] & ~(iss_vld_p1 & (iss_id_p1 == 1'(i)));
  end

  // Grant selection and next-state/pointer logic.
  always_comb begin
    grant     = '0;
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ARB: begin
        if (elig[ptr])       grant[ptr]  = 1'b1;
        else if (elig[~ptr]) grant[~ptr] = 1'b1;
      end
      LOCK0:   grant[0] = elig[0];
      LOCK1:   grant[1] = elig[1];
      default: ;
    endcase
    req_ready = reset ? 2'b00 : grant;
    acc_id    = req_ready[1];
    if (|req_ready) begin
      if (req_lock[acc_id]) begin
        state_nxt = acc_id ? LOCK1 : LOCK0;
      end else begin
        state_nxt = ARB;
        ptr_nxt   = ~acc_id;
      end
    end
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // ---- p0 -> p1: accepted request into the issue stage ----
  // Issue-stage occupancy.
  always_ff @(posedge clk) begin
    if (reset) iss_vld_p1 <= 1'b0;
    else       iss_vld_p1 <= |req_ready;
  end

  // Issue-stage operands; cin folds in the requester's own carry flag.
  always_ff @(posedge clk) begin
    if (|req_ready) begin
      iss_id_p1  <= acc_id;
      iss_a_p1   <= acc_id ? req_a[2*W-1:W] : req_a[W-1:0];
      iss_b_p1   <= acc_id ? req_b[2*W-1:W] : req_b[W-1:0];
      iss_sel_p1 <= acc_id ? req_sel[2*SEL_W-1:SEL_W] : req_sel[SEL_W-1:0];
      iss_cin_p1 <= carry[acc_id] & req_use_c[acc_id];
    end
  end

  alu_8bit u_alu (
    .a        (iss_a_p1),
    .b        (iss_b_p1),
    .alu_sel  (iss_sel_p1),
    .cin      (iss_cin_p1),
    .alu_out  (alu_out),
    .alu_cout (alu_cout)
  );

  // ---- p1 -> p2: ALU result into the owner's buffer and carry flag ----
  // Result buffers are cleared on reset so no stale result is ever shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= '0;
      out_p2  <= '0;
      cout_p2 <= '0;
      carry   <= '0;
    end else begin
      vld_p2 <= vld_p2 & ~(vld_p2 & rsp_ready);
      if (iss_vld_p1) begin
        vld_p2[iss_id_p1]  <= 1'b1;
        out_p2[iss_id_p1]  <= alu_out;
        cout_p2[iss_id_p1] <= alu_cout;
        carry[iss_id_p1]   <= alu_cout;
      end
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_out   = out_p2;
  assign rsp_cout  = cout_p2;
  assign busy      = iss_vld_p1 | (state != ARB);

endmodule

// File: tb/tb_alu_sched_2req.sv
// Scoreboard bench for alu_sched_2req: accepted requests push an expected
// result computed by a reference ALU; a negedge monitor checks grants, busy,
// response latency and response data.
module tb_alu_sched_2req;
  import alu_sched_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [1:0]         req_valid = '0, req_use_c = '0, req_lock = '0, rsp_ready = '0;
  logic [1:0]         req_ready, rsp_valid, rsp_cout;
  logic [2*W-1:0]     req_a = '0, req_b = '0, rsp_out;
  logic [2*SEL_W-1:0] req_sel = '0;
  logic               busy;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic rst_q = 1'b0;

  typedef struct packed {
    logic       id;
    logic [7:0] out;
    logic       cout;
    int         acc_cyc;
  } exp_t;
  exp_t sb[$];

  int   ptr_m = 0, lock_m = -1;
  logic [1:0] cf_m = '0, seen = '0;
  logic iss_m = 1'b0;

  always #5 clk = ~clk;

  alu_sched_2req dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_use_c(req_use_c),
    .req_lock(req_lock), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_cout(rsp_cout), .busy(busy)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void alu_ref(input int a, input int b, input int sel, input int cin,
                                  output logic [7:0] o, output logic c);
    int r;
    r = 0;
    c = 1'b0;
    case (sel)
      0: begin r = a + b + cin; c = (r > 255); r = r % 256; end
      1: begin r = a - b - cin; c = (r < 0); if (r < 0) r = r + 256; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = (a * 2) % 256; c = (a >= 128); end
      7: begin r = a / 2; c = (a % 2 == 1); end
      default: r = 0;
    endcase
    o = r[7:0];
  endfunction

  function automatic int find(input logic id);
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].id == id) return k;
    return -1;
  endfunction

  always @(posedge clk) rst_q <= reset;

  // Monitor: grant/busy model, response checks, then record new accepts.
  always @(negedge clk) begin
    logic [1:0] elig, exp_g, acc;
    int idx;
    logic [7:0] o;
    logic c;
    exp_t e;
    cyc++;
    if (reset) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      if (rst_q) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
      end
      sb.delete();
      ptr_m = 0; lock_m = -1; cf_m = '0; iss_m = 1'b0; seen = '0;
    end else begin
      for (int i = 0; i < 2; i++)
        elig[i] = req_valid[i] && (find(1'(i)) < 0);
      exp_g = '0;
      if (lock_m >= 0) begin
        if (elig[lock_m]) exp_g[lock_m] = 1'b1;
      end else if (elig[ptr_m]) exp_g[ptr_m] = 1'b1;
      else if (elig[1-ptr_m]) exp_g[1-ptr_m] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_g));
      chk("busy", 32'(busy), 32'(iss_m || lock_m >= 0));

      for (int i = 0; i < 2; i++) begin
        idx = find(1'(i));
        if (rsp_valid[i]) begin
          if (idx < 0) chk($sformatf("rsp_spurious%0d", i), 32'(rsp_valid[i]), 32'd0);
          else begin
            if (!seen[i]) chk($sformatf("latency%0d", i), 32'(cyc - sb[idx].acc_cyc), 32'd2);
            seen[i] = 1'b1;
            chk($sformatf("rsp_out%0d", i), 32'(rsp_out[i*8 +: 8]), 32'(sb[idx].out));
            chk($sformatf("rsp_cout%0d", i), 32'(rsp_cout[i]), 32'(sb[idx].cout));
            if (rsp_ready[i]) begin
              sb.delete(idx);
              seen[i] = 1'b0;
            end
          end
        end else if (idx >= 0 && cyc - sb[idx].acc_cyc >= 2) begin
          chk($sformatf("rsp_missing%0d", i), 32'(rsp_valid[i]), 32'd1);
        end
      end

      acc = req_valid & req_ready;
      iss_m = (acc != 2'b00);
      if (acc != 2'b00) begin
        e.id = acc[1];
        alu_ref(int'(req_a[e.id*8 +: 8]), int'(req_b[e.id*8 +: 8]),
                int'(req_sel[e.id*4 +: 4]), int'(cf_m[e.id] & req_use_c[e.id]), o, c);
        e.out = o; e.cout = c; e.acc_cyc = cyc;
        sb.push_back(e);
        cf_m[e.id] = c;
        if (req_lock[e.id]) lock_m = int'(e.id);
        else begin lock_m = -1; ptr_m = 1 - int'(e.id); end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic setup(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic uc, input logic lk);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_sel[i*4 +: 4] = sel;
    req_use_c[i] = uc;
    req_lock[i] = lk;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_acc(input int i);
    bit got;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    if (!got) chk($sformatf("accept_timeout%0d", i), 32'd0, 32'd1);
    step();
    req_valid[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] sel, input logic uc, input logic lk);
    setup(i, a, b, sel, uc, lk);
    wait_acc(i);
  endtask

  task automatic rand_run(input int n, input int p_valid, input int p_lock, input int p_rdy);
    logic [1:0] a;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a = req_valid & req_ready;
      step();
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || a[i]) begin
          req_valid[i] = ($urandom % 100) < p_valid;
          req_a[i*8 +: 8] = 8'($urandom);
          req_b[i*8 +: 8] = 8'($urandom);
          req_sel[i*4 +: 4] = 4'($urandom % 16);
          req_use_c[i] = 1'($urandom);
          req_lock[i] = ($urandom % 100) < p_lock;
        end
        rsp_ready[i] = ($urandom % 100) < p_rdy;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b11;
    repeat (3) step();
    reset = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;

    // Single op on requester 0.
    send(0, 8'h0A, 8'h02, ALU_ADD, 1'b0, 1'b0);
    repeat (4) step();

    // Chained 16-bit add on requester 1 while requester 0 waits.
    setup(0, 8'h33, 8'h11, ALU_SUB, 1'b0, 1'b0);
    send(1, 8'hFF, 8'h01, ALU_ADD, 1'b0, 1'b1);
    send(1, 8'h00, 8'h00, ALU_ADD, 1'b1, 1'b0);
    wait_acc(0);
    repeat (4) step();

    // Backpressure on port 0 while port 1 keeps being served.
    rsp_ready = 2'b10;
    send(0, 8'h80, 8'h80, ALU_ADD, 1'b0, 1'b0);
    setup(0, 8'h05, 8'h07, ALU_SUB, 1'b0, 1'b0);
    send(1, 8'h12, 8'h34, ALU_ADD, 1'b0, 1'b0);
    send(1, 8'hF0, 8'h0F, 4'h4, 1'b0, 1'b0);
    repeat (3) step();
    rsp_ready = 2'b11;
    wait_acc(0);
    repeat (4) step();

    // Reset while locked on requester 1 with an op in the issue stage.
    send(1, 8'hFF, 8'h01, ALU_ADD, 1'b0, 1'b0);
    repeat (4) step();
    send(1, 8'hFF, 8'hFF, ALU_ADD, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    send(1, 8'h01, 8'h00, ALU_ADD, 1'b1, 1'b0);
    repeat (4) step();

    // Round robin with both always valid, then fully random traffic.
    rand_run(40, 100, 0, 100);
    rand_run(400, 60, 25, 60);
    rand_run(30, 100, 0, 100);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (8) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
